// File: rtl/cpu_trace_pkg.sv
// Shared encodings and defaults for the CPU trace buffer.
// Imported by the buffer top and its storage.
package cpu_trace_pkg;

   localparam int DefDataW = 32;
   localparam int DefCh    = 4;
   localparam int DefDepth = 16;

   localparam logic [1:0] ModeWrap     = 2'd0;
   localparam logic [1:0] ModeStopFull = 2'd1;
   localparam logic [1:0] ModeTrigger  = 2'd2;
   localparam logic [1:0] ModeRsvd     = 2'd3;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StArmed   = 2'd1;
   localparam logic [1:0] StCapture = 2'd2;
   localparam logic [1:0] StDone    = 2'd3;

   // Every mode other than wrap ends the capture once the buffer fills.
   function automatic logic endsWhenFull(input logic [1:0] m);
      return m != ModeWrap;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
// Contents are never reset; only the read register is.
module trace_ram
   import cpu_trace_pkg::*;
#(
   parameter int WIDTH = (DefCh + 1) * DefDataW,
   parameter int DEPTH = DefDepth,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             wrEn,
   input  logic [AW-1:0]    wrAddr,
   input  logic [WIDTH-1:0] wrData,
   input  logic             rdEn,
   input  logic [AW-1:0]    rdAddr,
   output logic [WIDTH-1:0] rdData
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         rdData <= '0;
      end else if (rdEn) begin
         rdData <= mem[rdAddr];
      end
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Capture buffer for retired-instruction PC and datapath channels.
// Wrap, stop-when-full and PC-trigger capture modes; drained in DONE.
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int DATA_W = DefDataW,
   parameter int CH     = DefCh,
   parameter int DEPTH  = DefDepth
) (
   input  logic                         clk,
   input  logic                         Rst,
   input  logic                         arm,
   input  logic                         stop,
   input  logic [1:0]                   mode,
   input  logic [DATA_W-1:0]            trig_pc,
   input  logic                         valid,
   input  logic [DATA_W-1:0]            pc,
   input  logic [CH*DATA_W-1:0]         ch_data,
   input  logic                         rd_en,
   output logic [(CH+1)*DATA_W-1:0]     rd_data,
   output logic                         rd_valid,
   output logic [$clog2(DEPTH):0]       count,
   output logic [1:0]                   state,
   output logic                         overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = (CH + 1) * DATA_W;
   localparam logic [CW-1:0] Full    = CW'(DEPTH);
   localparam logic [CW-1:0] AlmostF = CW'(DEPTH - 1);

   logic [AW-1:0]     wrPtr;
   logic [AW-1:0]     rdPtr;
   logic [CW-1:0]     cnt;
   logic [1:0]        stQ;
   logic [1:0]        modeQ;
   logic [DATA_W-1:0] trigQ;
   logic              ovfQ;
   logic              rdValidQ;

   logic isFull;
   logic capturing;
   logic trigHit;
   logic wrEn;
   logic rdEn;
   logic lastWr;

   assign isFull    = cnt == Full;
   assign capturing = stQ == StCapture;
   assign trigHit   = stQ == StArmed && pc == trigQ;

   // arm and stop both pre-empt a same-cycle sample.
   assign wrEn = !arm && !stop && valid
               && (capturing || trigHit);

   assign rdEn = !arm && rd_en && stQ == StDone
               && cnt != '0;

   // No reads happen while capturing, so cnt is the
   // total write count in the non-wrap modes.
   assign lastWr = wrEn && endsWhenFull(modeQ)
                 && cnt == AlmostF;

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         stQ      <= StIdle;
         wrPtr    <= '0;
         rdPtr    <= '0;
         cnt      <= '0;
         ovfQ     <= 1'b0;
         modeQ    <= ModeWrap;
         trigQ    <= '0;
         rdValidQ <= 1'b0;
      end else if (arm) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         cnt      <= '0;
         ovfQ     <= 1'b0;
         modeQ    <= mode;
         trigQ    <= trig_pc;
         rdValidQ <= 1'b0;
         stQ      <= (mode == ModeTrigger) ? StArmed
                                           : StCapture;
      end else begin
         rdValidQ <= rdEn;
         if (wrEn) begin
            wrPtr <= wrPtr + 1'b1;
            if (isFull) begin
               rdPtr <= rdPtr + 1'b1;
               ovfQ  <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (rdEn) begin
            rdPtr <= rdPtr + 1'b1;
            cnt   <= cnt - 1'b1;
         end
         unique case (1'b1)
            stop && (stQ == StArmed || capturing):
               stQ <= StDone;
            lastWr:
               stQ <= StDone;
            wrEn && stQ == StArmed:
               stQ <= StCapture;
            default:
               stQ <= stQ;
         endcase
      end
   end

   trace_ram #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) uRam (
      .clk    (clk),
      .Rst    (Rst),
      .wrEn   (wrEn),
      .wrAddr (wrPtr),
      .wrData ({ch_data, pc}),
      .rdEn   (rdEn),
      .rdAddr (rdPtr),
      .rdData (rd_data)
   );

   assign rd_valid = rdValidQ;
   assign count    = cnt;
   assign state    = stQ;
   assign overflow = ovfQ;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer at DEPTH = 8, CH = 4.
module tb_cpu_trace_buffer;

   localparam int DW = 32;
   localparam int NC = 4;
   localparam int DP = 8;
   localparam int EW = (NC + 1) * DW;

   logic           clk = 1'b0;
   logic           Rst = 1'b0;
   logic           arm = 1'b0;
   logic           stop = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic [DW-1:0]  trig_pc = '0;
   logic           valid = 1'b0;
   logic [DW-1:0]  pc = '0;
   logic [NC*DW-1:0] ch_data = '0;
   logic           rd_en = 1'b0;
   logic [EW-1:0]  rd_data;
   logic           rd_valid;
   logic [3:0]     count;
   logic [1:0]     state;
   logic           overflow;

   int checks = 0;
   int failures = 0;
   logic [EW-1:0] sb [$];

   cpu_trace_buffer #(
      .DATA_W (DW),
      .CH     (NC),
      .DEPTH  (DP)
   ) dut (
      .clk      (clk),
      .Rst      (Rst),
      .arm      (arm),
      .stop     (stop),
      .mode     (mode),
      .trig_pc  (trig_pc),
      .valid    (valid),
      .pc       (pc),
      .ch_data  (ch_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .state    (state),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [NC*DW-1:0] chOf(input logic [DW-1:0] p);
      logic [NC*DW-1:0] c;
      for (int i = 0; i < NC; i++) begin
         c[i*DW +: DW] = p ^ (DW'(i + 1) << 24);
      end
      return c;
   endfunction

   function automatic logic [EW-1:0] entry(input logic [DW-1:0] p);
      return {chOf(p), p};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic a, input logic s, input logic v,
                       input logic r, input logic [DW-1:0] p);
      arm = a;
      stop = s;
      valid = v;
      rd_en = r;
      pc = p;
      ch_data = chOf(p);
      @(negedge clk);
   endtask

   task automatic readN(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         sb.push_back(entry(base + DW'(4 * i)));
         step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   // Monitor: every rd_valid strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (rd_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected actual pc=%0h required=none",
                     rd_data[DW-1:0]);
         end else begin
            logic [EW-1:0] e;
            e = sb.pop_front();
            if (rd_data !== e) begin
               failures++;
               $display("FAIL rd_data actual pc=%0h required pc=%0h",
                        rd_data[DW-1:0], e[DW-1:0]);
            end
         end
      end
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_state", 32'(state), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_rdv", 32'(rd_valid), 0);
      chk("rst_rdata", rd_data[31:0], 0);
      Rst = 1'b1;
      @(negedge clk);

      // Stop-when-full
      mode = 2'd1;
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      chk("swf_arm_state", 32'(state), 2);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, DW'(i * 4));
         chk("swf_state", 32'(state), (i < 7) ? 2 : 3);
      end
      chk("swf_count", 32'(count), 8);
      chk("swf_ovf", 32'(overflow), 0);
      sb.push_back(entry(0));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      chk("lat_rdv", 32'(rd_valid), 1);
      chk("lat_count", 32'(count), 7);
      readN(7, 32'h04);
      chk("swf_drained", 32'(count), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      chk("empty_rd_rdv", 32'(rd_valid), 0);
      chk("empty_state", 32'(state), 3);

      // Wrap
      mode = 2'd0;
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 11; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, DW'(i * 4));
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("wrap_state", 32'(state), 3);
      chk("wrap_count", 32'(count), 8);
      chk("wrap_ovf", 32'(overflow), 1);
      readN(8, 32'h0C);

      // Trigger
      mode = 2'd2;
      trig_pc = 32'h40;
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      chk("trig_ovf_clr", 32'(overflow), 0);
      chk("trig_arm_state", 32'(state), 1);
      for (int p = 'h30; p <= 'h80; p += 4) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, DW'(p));
         chk("trig_state", 32'(state),
             (p < 'h40) ? 1 : (p < 'h5C) ? 2 : 3);
      end
      chk("trig_count", 32'(count), 8);
      readN(8, 32'h40);

      // arm + stop together, reads in CAPTURE, stop + valid together
      mode = 2'd1;
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      chk("cfl_state", 32'(state), 2);
      chk("cfl_count", 32'(count), 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h104);
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      chk("cap_rd_rdv", 32'(rd_valid), 0);
      chk("cap_rd_count", 32'(count), 2);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h108);
      chk("stopv_state", 32'(state), 3);
      chk("stopv_count", 32'(count), 2);
      readN(2, 32'h100);

      // Mode 3 ends like stop-when-full
      mode = 2'd3;
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'h200 + DW'(i * 4));
      end
      chk("m3_state", 32'(state), 3);
      chk("m3_count", 32'(count), 8);

      // Reset mid-capture
      mode = 2'd0;
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'h300 + DW'(i * 4));
      end
      chk("pre_rst_count", 32'(count), 3);
      #2 Rst = 1'b0;
      #1;
      chk("arst_state", 32'(state), 0);
      chk("arst_count", 32'(count), 0);
      @(negedge clk);
      Rst = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      chk("rearm_state", 32'(state), 2);
      chk("rearm_count", 32'(count), 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h400);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h404);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("fresh_count", 32'(count), 2);
      readN(2, 32'h400);

      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
